// File: rtl/prog_clk_div.sv
// prog_clk_div: runtime-programmable square-wave / tick generator.
// A half-period counter toggles o_sq every o_div_act enabled cycles. A new
// divisor written through i_div/i_div_wr is held as pending and only takes
// effect at a half-period boundary, so rate changes never produce runt pulses.
// Optional feature macro: PHASE_SYNC_EN adds the i_sync phase-realign input.
//
// Divisor update protocol: i_div_wr is a one-cycle strobe that captures i_div
// (0 is clamped to 1) as the pending divisor; there is no back-pressure and a
// later write before the reload simply replaces the pending value. o_div_ack
// pulses for one cycle, in the same registered update where o_div_act takes
// the new value. A write in the boundary cycle itself waits for the next one.
module prog_clk_div #(
  parameter int DIV_WIDTH   = 17,
  parameter int DEFAULT_DIV = 50_000
) (
  input  logic                 clk_100MHz,
  input  logic                 reset,
  input  logic                 i_enable,
  input  logic [DIV_WIDTH-1:0] i_div,
  input  logic                 i_div_wr,
`ifdef PHASE_SYNC_EN
  input  logic                 i_sync,
`endif
  output logic                 o_sq,
  output logic                 o_tick,
  output logic                 o_div_ack,
  output logic [DIV_WIDTH-1:0] o_div_act,
  output logic [1:0]           o_state_dbg
);

  typedef enum logic [1:0] {
    ST_STOP     = 2'd0,
    ST_RUN      = 2'd1,
    ST_RUN_PEND = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] act_q, act_d;
  logic [DIV_WIDTH-1:0] pval_q, pval_d;
  logic                 pend_q, pend_d;
  logic                 sq_q, sq_d;
  logic                 tick_q, tick_d;
  logic                 ack_q, ack_d;
  logic                 sync_w;
  logic                 boundary_w;

`ifdef PHASE_SYNC_EN
  assign sync_w = i_sync;
`else
  assign sync_w = 1'b0;
`endif

  // Last cycle of the current half-period.
  assign boundary_w = (cnt_q == (act_q - DIV_WIDTH'(1)));

  // State register: FSM plus the counter/output datapath it controls.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q <= ST_STOP;
      cnt_q   <= '0;
      act_q   <= DIV_WIDTH'(DEFAULT_DIV);
      pval_q  <= '0;
      pend_q  <= 1'b0;
      sq_q    <= 1'b0;
      tick_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      pval_q  <= pval_d;
      pend_q  <= pend_d;
      sq_q    <= sq_d;
      tick_q  <= tick_d;
      ack_q   <= ack_d;
    end
  end

  // Next state: STOP whenever disabled, otherwise RUN or RUN_PEND by pending flag.
  always_comb begin
    state_d = state_q;
    if (!i_enable) begin
      state_d = ST_STOP;
    end else if (pend_d) begin
      state_d = ST_RUN_PEND;
    end else begin
      state_d = ST_RUN;
    end
  end

  // Outputs/datapath: counting, toggling, boundary reload and pending capture.
  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    pval_d = pval_q;
    pend_d = pend_q;
    sq_d   = sq_q;
    tick_d = 1'b0;
    ack_d  = 1'b0;
    if (sync_w) begin
      // Realign phase; any pending divisor is applied right away.
      cnt_d = '0;
      sq_d  = 1'b0;
      if (pend_q) begin
        act_d  = pval_q;
        ack_d  = 1'b1;
        pend_d = 1'b0;
      end
    end else if (i_enable) begin
      if (boundary_w) begin
        cnt_d  = '0;
        sq_d   = ~sq_q;
        tick_d = ~sq_q;
        if (pend_q) begin
          act_d  = pval_q;
          ack_d  = 1'b1;
          pend_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + DIV_WIDTH'(1);
      end
    end
    // A write in the reload cycle becomes the next pending value.
    if (i_div_wr) begin
      pend_d = 1'b1;
      pval_d = (i_div == '0) ? DIV_WIDTH'(1) : i_div;
    end
  end

  assign o_sq        = sq_q;
  assign o_tick      = tick_q;
  assign o_div_ack   = ack_q;
  assign o_div_act   = act_q;
  assign o_state_dbg = state_q;

endmodule

// File: tb/tb_prog_clk_div.sv
// Testbench for prog_clk_div (DIV_WIDTH=8, DEFAULT_DIV=4). A behavioural
// model predicts o_sq/o_tick/o_div_ack/o_div_act each cycle into exp_q; a
// compare process checks every cycle, and directed literals pin the model.
module tb_prog_clk_div;
  localparam int W   = 8;
  localparam int DEF = 4;
  localparam int EW  = W + 3;

  // Clock / reset block
  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         en    = 1'b0;
  logic         wr    = 1'b0;
  logic         sync  = 1'b0;
  logic [W-1:0] div   = '0;
  logic         sq, tick, ack;
  logic [W-1:0] act;
  logic [1:0]   st;

  always #5 clk = ~clk;

  prog_clk_div #(.DIV_WIDTH(W), .DEFAULT_DIV(DEF)) dut (
    .clk_100MHz (clk),
    .reset      (reset),
    .i_enable   (en),
    .i_div      (div),
    .i_div_wr   (wr),
`ifdef PHASE_SYNC_EN
    .i_sync     (sync),
`endif
    .o_sq       (sq),
    .o_tick     (tick),
    .o_div_ack  (ack),
    .o_div_act  (act),
    .o_state_dbg(st)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Behavioural model: elapsed enabled cycles in the half-period, toggle at D.
  int m_pos, m_act, m_pval;
  bit m_sq, m_tick, m_ack, m_pend;

  task automatic model_step();
    int nv;
    nv = (div == '0) ? 1 : int'(div);
    if (reset) begin
      m_pos = 0; m_sq = 0; m_tick = 0; m_ack = 0;
      m_act = DEF; m_pend = 0; m_pval = 0;
    end else begin
      m_tick = 0;
      m_ack  = 0;
      if (sync) begin
        m_pos = 0;
        m_sq  = 0;
        if (m_pend) begin m_act = m_pval; m_ack = 1; m_pend = 0; end
      end else if (en) begin
        m_pos++;
        if (m_pos >= m_act) begin
          m_pos  = 0;
          m_sq   = !m_sq;
          m_tick = m_sq;
          if (m_pend) begin m_act = m_pval; m_ack = 1; m_pend = 0; end
        end
      end
      if (wr) begin m_pend = 1; m_pval = nv; end
    end
    exp_q.push_back({m_sq, m_tick, m_ack, W'(m_act)});
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Scoreboard compare: every cycle, away from the active edge
  initial forever begin
    logic [EW-1:0] e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cycle_sq",   32'(sq),   32'(e[EW-1]));
      check("cycle_tick", 32'(tick), 32'(e[EW-2]));
      check("cycle_ack",  32'(ack),  32'(e[EW-3]));
      check("cycle_act",  32'(act),  32'(e[W-1:0]));
    end
  end

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_div(input logic [W-1:0] v);
    div = v;
    wr  = 1'b1;
    step(1);
    wr  = 1'b0;
  endtask

  task automatic wait_ack(input int max, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max; i++) begin
      step(1);
      if (ack) begin cyc = i; break; end
    end
    if (cyc < 0) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_pos(input int p, input bit need_sq);
    bit hit;
    hit = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_pos == p && (!need_sq || m_sq)) begin hit = 1; break; end
      step(1);
    end
    if (!hit) check("pos_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int cyc, acks;
    logic s0;
    // Reset state
    en = 1'b1;
    step(3);
    check("rst_sq",   32'(sq),   32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_ack",  32'(ack),  32'd0);
    check("rst_act",  32'(act),  32'd4);
    check("rst_st",   32'(st),   32'd0);
    reset = 1'b0;

    // Default divisor: rise after edge 4, fall after edge 8
    step(4);
    check("first_rise", 32'(sq),   32'd1);
    check("first_tick", 32'(tick), 32'd1);
    step(1);
    check("tick_one_cycle", 32'(tick), 32'd0);
    step(3);
    check("first_fall", 32'(sq), 32'd0);

    // Mid-half-period write of 3: ack at the next boundary
    step(1);
    write_div(8'd3);
    check("pend_state", 32'(st),  32'd2);
    check("pend_act",   32'(act), 32'd4);
    wait_ack(10, cyc);
    check("mid_ack_lat", 32'(cyc), 32'd2);
    check("mid_act",     32'(act), 32'd3);
    check("run_state",   32'(st),  32'd1);
    step(12);

    // Write in the boundary cycle: applied one boundary later
    wait_pos(2, 1'b0);
    write_div(8'd5);
    check("bnd_noack", 32'(ack), 32'd0);
    check("bnd_act",   32'(act), 32'd3);
    wait_ack(10, cyc);
    check("bnd_ack_lat", 32'(cyc), 32'd3);
    check("bnd_act_new", 32'(act), 32'd5);

    // Two writes before one boundary: last wins, single ack
    write_div(8'd6);
    write_div(8'd2);
    acks = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (ack) acks++;
    end
    check("overwrite_acks", 32'(acks), 32'd1);
    check("overwrite_act",  32'(act),  32'd2);

    // Freeze at cnt=2 for 5 cycles, then boundary 2 cycles after resume
    write_div(8'd4);
    wait_ack(10, cyc);
    wait_pos(2, 1'b0);
    s0 = sq;
    en = 1'b0;
    step(5);
    check("frz_sq",   32'(sq),   32'(s0));
    check("frz_tick", 32'(tick), 32'd0);
    check("frz_st",   32'(st),   32'd0);
    en = 1'b1;
    step(1);
    check("resume_hold", 32'(sq), 32'(s0));
    step(1);
    check("resume_bnd", 32'(sq), 32'(!s0));

    // Divisor 0 clamps to 1: toggle every cycle, tick every other cycle
    write_div(8'd0);
    wait_ack(10, cyc);
    check("clamp_act", 32'(act), 32'd1);
    for (int i = 0; i < 4; i++) begin
      s0 = sq;
      step(1);
      check("d1_toggle", 32'(sq),   32'(!s0));
      check("d1_tick",   32'(tick), 32'(!s0));
    end

    // Reset while pending: back to default divisor, no ack
    write_div(8'd7);
    step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("rstp_act", 32'(act), 32'd4);
    check("rstp_ack", 32'(ack), 32'd0);
    check("rstp_sq",  32'(sq),  32'd0);
    step(20);

`ifdef PHASE_SYNC_EN
    // Sync at cnt=2 with o_sq=1: drop to 0, rise D later, then every 2*D
    wait_pos(2, 1'b1);
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    check("sync_sq",   32'(sq),   32'd0);
    check("sync_tick", 32'(tick), 32'd0);
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (sq) begin cyc = i; break; end
    end
    check("sync_rise", 32'(cyc), 32'd4);
    step(1);
    cyc = -1;
    for (int i = 2; i <= 20; i++) begin
      step(1);
      if (tick) begin cyc = i; break; end
    end
    check("sync_period", 32'(cyc), 32'd8);
`endif

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
